// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Works on operand magnitudes for 32 cycles, then fixes up signs in a final SIGN cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  state_t             state;
  logic [5:0]         cnt;
  logic [2*WIDTH-1:0] acc;   // multiply: {partial product, multiplier}; divide: low half is dividend/quotient
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   opnd;  // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;

  logic               a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    a_neg     = op[0] & op_a[WIDTH-1];
    b_neg     = op[0] & op_b[WIDTH-1];
    abs_a     = a_neg ? -op_a : op_a;
    abs_b     = b_neg ? -op_b : op_b;
    div_zero  = op[1] && (op_b == '0);
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Restoring step: a borrow out of the top bit means the trial subtraction failed.
    div_shift = {rem, acc[WIDTH-1]};
    div_diff  = div_shift - {2'b00, opnd};
    prod_fix  = neg_res ? -acc : acc;
    quot_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      rem         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (div_zero) begin
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              opnd    <= op[1] ? abs_b : abs_a;
              acc     <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
              rem     <= '0;
              is_div  <= op[1];
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              cnt     <= '0;
              busy    <= 1'b1;
              state   <= CALC;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          if (is_div) begin
            rem              <= div_diff[WIDTH+1] ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], ~div_diff[WIDTH+1]};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + 6'd1;
          if (cnt == LAST_ITER) state <= SIGN;
        end
        SIGN: begin
          if (is_div) begin
            lo <= quot_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
// Expected HI/LO come from 64-bit arithmetic on the operands; a monitor checks each done pulse.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] op_a, op_b, wdata;
  logic [31:0] hi, lo;
  logic        busy, done, div_by_zero;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [63:0] p, q, m;
    longint      sa, sb_v;
    r.dbz = 1'b0;
    if (o[1] && b == 32'd0) begin
      r.hi = m_hi; r.lo = m_lo; r.dbz = 1'b1;
      return r;
    end
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    case (o)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b01: begin p = sa * sb_v; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b10: begin r.lo = a / b; r.hi = a % b; end
      default: begin q = sa / sb_v; m = sa % sb_v; r.lo = q[31:0]; r.hi = m[31:0]; end
    endcase
    return r;
  endfunction

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        e_mon = sb.pop_front();
        check32("result_hi", hi, e_mon.hi);
        check32("result_lo", lo, e_mon.lo);
        check32("div_by_zero_flag", {31'd0, div_by_zero}, {31'd0, e_mon.dbz});
        check32("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is high.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int inject);
    exp_t        e;
    int          k = 0;
    int          n = 0;
    logic [31:0] prev_hi, prev_lo;
    while (busy && k < 100) begin @(negedge clk); k++; end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_wait: got busy=1 expected 0 within 100 cycles");
    end
    prev_hi = m_hi; prev_lo = m_lo;
    e = model(o, a, b);
    sb.push_back(e);
    m_hi = e.hi; m_lo = e.lo;
    op = o; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy && n < 100) begin
      n++;
      check32("hold_hi", hi, prev_hi);
      check32("hold_lo", lo, prev_lo);
      if (n == inject) begin
        start = 1'b1; op = 2'b01; op_a = $urandom; op_b = $urandom;
        lo_we = 1'b1; wdata = 32'hDEAD;
      end else begin
        start = 1'b0; lo_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; lo_we = 1'b0;
    check32("busy_cycles", n, e.dbz ? 32'd0 : 32'd33);
  endtask

  task automatic mt(input logic sel_hi, input logic [31:0] d);
    hi_we = sel_hi; lo_we = ~sel_hi; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    if (sel_hi) m_hi = d; else m_lo = d;
    check32(sel_hi ? "mthi" : "mtlo", sel_hi ? hi : lo, d);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd1;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; op_a = '0; op_b = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check32("reset_hi", hi, 32'd0);
    check32("reset_lo", lo, 32'd0);
    check32("reset_busy", {31'd0, busy}, 32'd0);
    check32("reset_done", {31'd0, done}, 32'd0);
    check32("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check32("multu_max_hi", hi, 32'hFFFF_FFFE);
    check32("multu_max_lo", lo, 32'h0000_0001);
    issue(2'b01, 32'hFFFF_FFFA, 32'd5, 0);
    check32("mult_neg_lo", lo, 32'hFFFF_FFE2);
    issue(2'b01, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 0);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
    check32("div_neg_lo", lo, 32'hFFFF_FFFD);
    check32("div_neg_hi", hi, 32'hFFFF_FFFF);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check32("div_ovf_lo", lo, 32'h8000_0000);
    issue(2'b10, 32'd100, 32'd7, 0);

    mt(1'b1, 32'h11);
    mt(1'b0, 32'h22);
    issue(2'b10, 32'd5, 32'd0, 0);
    @(negedge clk);
    check32("dbz_keep_hi", hi, 32'h11);
    check32("dbz_keep_lo", lo, 32'h22);

    issue(2'b00, 32'd3, 32'd4, 10);
    check32("ignored_inputs_lo", lo, 32'd12);

    // Abort a divide partway through with an asynchronous reset.
    op = 2'b11; op_a = 32'h1234_5678; op_b = 32'h0000_0013; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check32("abort_busy", {31'd0, busy}, 32'd0);
    check32("abort_hi", hi, 32'd0);
    check32("abort_lo", lo, 32'd0);
    check32("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    issue(2'b00, 32'd7, 32'd8, 0);
    check32("after_abort_lo", lo, 32'd56);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = pick();
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : pick();
      if ($urandom_range(0, 6) == 0) mt($urandom_range(0, 1) == 1, $urandom);
      issue(2'(($urandom_range(0, 3))), ra, rb, 0);
    end

    repeat (3) @(negedge clk);
    check32("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle integer multiply/divide unit for the EXE stage of the pipelined MIPS core. It runs beside the single-cycle ALU and takes its operands from the forwarded EXE operands (`Op1`/`Op2` after the forwarding muxes). It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers that MFHI/MFLO read. `busy` feeds the hazard detection unit so the pipeline stalls instructions that touch HI/LO or start a new operation while one is in flight.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  launch the operation selected by `op`; sampled only in IDLE.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `op_a`  in  WIDTH  multiplicand or dividend (rs).
- `op_b`  in  WIDTH  multiplier or divisor (rt).
- `hi_we`  in  1  MTHI: write `wdata` to HI.
- `lo_we`  in  1  MTLO: write `wdata` to LO.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `hi`  out  WIDTH  HI register (MFHI source).
- `lo`  out  WIDTH  LO register (MFLO source).
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO take a result.
- `div_by_zero`  out  1  one-cycle pulse when a divide is rejected because `op_b`=0.

## Operation
- The FSM has three states: IDLE, CALC and SIGN. `busy` is high in CALC and SIGN.
- **IDLE with `start`=1, normal case:**
  - Latch the operand magnitudes. For signed ops, take the two's-complement absolute value; for unsigned ops, use the operands as-is.
  - Latch the sign flags: `neg_res` = `op_a`[31] XOR `op_b`[31], and `neg_rem` = `op_a`[31]. Both flags are 0 for unsigned ops.
  - Clear the 6-bit iteration counter and go to CALC.
- **Divide by zero:** if `start`=1 with op 10 or 11 and `op_b`=0, stay in IDLE. HI/LO are unchanged. Pulse `done` and `div_by_zero` in the next cycle.
- **CALC, multiply:** radix-2 shift-add over a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- **CALC, divide:** restoring division, one quotient bit per cycle. The remainder register is WIDTH+1 bits.
- **CALC exit:** after exactly 32 iterations (counter 0..31), go to SIGN.
- **SIGN:**
  - Multiply: {HI,LO} = `neg_res` ? −product : product, as a 64-bit negation.
  - Divide: LO = `neg_res` ? −quotient : quotient, and HI = `neg_rem` ? −remainder : remainder.
  - Go to IDLE and set `done` for one cycle.
- **Overflow case:** DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This is the natural result of the magnitude algorithm.
- **MTHI/MTLO:** `hi_we`/`lo_we` write at the edge only in IDLE with `start`=0.
  - While busy they are ignored; the hazard unit must stall them.
  - If `start` and a write enable are high together, `start` wins and the write is dropped.
- **`start` in CALC/SIGN:** ignored. Operands are not re-latched.

## Timing
- **Reset values:** state IDLE; `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0; counter 0.
- **Reset mid-operation:** asynchronous abort. All outputs return to their reset values immediately, and any partial result is discarded.
- **Latency** (start sampled at edge E0):
  - `busy` rises after E0.
  - CALC iterations occur at edges E1..E32.
  - SIGN occurs at E33. HI/LO update at E33; `busy` falls and `done` rises after E33.
  - The result is visible on `hi`/`lo` 33 cycles after the start edge.
  - Back-to-back: a new `start` is accepted at E34 at the earliest, i.e. in the cycle `done` is high.
- **Divide-by-zero:** `done` and `div_by_zero` are high during the cycle after E0; `busy` never rises.
- **MTHI/MTLO:** written value appears on `hi`/`lo` after the same edge.
- `hi` and `lo` are register outputs with no combinational path from inputs. They are stable throughout CALC and SIGN until E33.

## Test plan
- **MULTU:** `op_a`=`op_b`=0xFFFFFFFF, `start` at E0. Expect `busy` for 33 cycles; `done` after E33; HI=0xFFFFFFFE, LO=0x00000001.
- **MULT, negative result:** −6 × 5 (0xFFFFFFFA, 0x00000005). Expect HI=0xFFFFFFFF, LO=0xFFFFFFE2. Then MULT −6 × −5: expect HI=0, LO=30.
- **DIV and DIVU:**
  - DIV −7 / 2: expect LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - DIV 0x80000000 / 0xFFFFFFFF: expect LO=0x80000000, HI=0.
  - DIVU 100 / 7: expect LO=14, HI=2.
- **Divide by zero:** MTHI 0x11, MTLO 0x22, then DIVU 5 / 0. Expect `done` and `div_by_zero` pulse one cycle later, `busy` stays 0, HI=0x11, LO=0x22.
- **Ignored inputs while busy:** start MULTU 3×4. At E10, assert `start` with new operands and `lo_we`=1, `wdata`=0xDEAD. Expect both ignored and the final HI=0, LO=12 at E33.
- **Reset mid-operation:** start DIV, assert `rst` at E15. Expect HI=LO=0, `busy`=0 and no `done`. A later MULTU 7×8 completes normally with LO=56.
